// File: rtl/mem1_pkg.sv
// Shared constants, word type and depth helper for the mem1 dual-port RAM.
package mem1_pkg;
  localparam int MEM1_DATA_WIDTH = 8;
  localparam int MEM1_MEM_SIZE   = 64;
  localparam int MEM1_ADDR_WIDTH = 4;

  typedef logic [MEM1_DATA_WIDTH-1:0] mem1_word_t;

  // Usable words: the array is never larger than the address space can reach.
  function automatic int mem1_depth(input int mem_size, input int addr_width);
    int span;
    span = 1 << addr_width;
    return (mem_size < span) ? mem_size : span;
  endfunction
endpackage

// File: rtl/mem1_array.sv
// Storage, write port and combinational in-range read mux for mem1_dp_ram.
// Optional MEM1_RESET_CLEAR_EN: synchronous reset also zeroes every word.
module mem1_array
  import mem1_pkg::*;
#(
  parameter int DATA_WIDTH = MEM1_DATA_WIDTH,
  parameter int MEM_SIZE   = MEM1_MEM_SIZE,
  parameter int ADDR_WIDTH = MEM1_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = mem1_depth(MEM_SIZE, ADDR_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      widx, ridx;
  logic                  wr_ok, rd_ok;

  // Index only the bits the array needs; the range check guards the rest.
  assign widx  = IDX_W'(write_address);
  assign ridx  = IDX_W'(read_address);
  assign wr_ok = {1'b0, write_address} < DEPTH_L;
  assign rd_ok = {1'b0, read_address}  < DEPTH_L;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (write_en && wr_ok) mem[widx] <= data_in;
    end
`ifdef MEM1_RESET_CLEAR_EN
    else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end
`endif
  end

  assign rd_data = rd_ok ? mem[ridx] : '0;
endmodule

// File: rtl/mem1_dp_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Optional MEM1_RESET_CLEAR_EN: reset clears the array as well as data_out.
module mem1_dp_ram
  import mem1_pkg::*;
#(
  parameter int DATA_WIDTH = MEM1_DATA_WIDTH,
  parameter int MEM_SIZE   = MEM1_MEM_SIZE,
  parameter int ADDR_WIDTH = MEM1_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic [DATA_WIDTH-1:0] rd_data;

  mem1_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_SIZE  (MEM_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_en     (write_en),
    .write_address(write_address),
    .data_in      (data_in),
    .read_address (read_address),
    .rd_data      (rd_data)
  );

  // rd_data reflects the array before this edge's write lands: read-first.
  always_ff @(posedge clk) begin
    if (!rst_n)       data_out <= '0;
    else if (read_en) data_out <= rd_data;
  end
endmodule

// File: tb/tb_mem1_dp_ram.sv
// Self-checking bench for mem1_dp_ram: vector table plus model-driven scoreboard.
module tb_mem1_dp_ram;
  import mem1_pkg::*;

`ifdef MEM1_RESET_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, write_en = 1'b0, read_en = 1'b0;
  logic [3:0] write_address = '0, read_address = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;

  always #5 clk = ~clk;

  mem1_dp_ram dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_en     (write_en),
    .write_address(write_address),
    .data_in      (data_in),
    .read_en      (read_en),
    .read_address (read_address),
    .data_out     (data_out)
  );

  typedef struct {
    logic       r;
    logic       we;
    logic [3:0] wa;
    logic [7:0] din;
    logic       re;
    logic [3:0] ra;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs[21];
  logic [7:0] sb_q[$];
  logic [7:0] model[16];
  logic [7:0] m_out;
  int         n_tests = 0, n_fail = 0;

  // Drive one cycle, queue its expected data_out, compare after the edge.
  task automatic cycle(input logic r, input logic we, input logic [3:0] wa,
                       input logic [7:0] din, input logic re, input logic [3:0] ra,
                       input logic [7:0] exp, input string name);
    logic [7:0] want;
    @(negedge clk);
    rst_n = r; write_en = we; write_address = wa; data_in = din;
    read_en = re; read_address = ra;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    n_tests++;
    if (data_out !== want) begin
      n_fail++;
      $display("FAIL %s: data_out=%h expected=%h", name, data_out, want);
    end
  endtask

  // Reference behaviour: read-first, reset clears output (and array if enabled).
  task automatic model_step(input logic r, input logic we, input logic [3:0] wa,
                            input logic [7:0] din, input logic re, input logic [3:0] ra,
                            output logic [7:0] exp);
    if (!r) begin
      m_out = 8'h00;
      if (CLR) for (int i = 0; i < 16; i++) model[i] = 8'h00;
    end else begin
      if (re) m_out = model[ra];
      if (we) model[wa] = din;
    end
    exp = m_out;
  endtask

  task automatic mcycle(input logic r, input logic we, input logic [3:0] wa,
                        input logic [7:0] din, input logic re, input logic [3:0] ra,
                        input string name);
    logic [7:0] e;
    model_step(r, we, wa, din, re, ra, e);
    cycle(r, we, wa, din, re, ra, e, name);
  endtask

  initial begin
    logic [7:0] after_rst_a2, after_rst_a1, after_rst_a0;
    after_rst_a2 = CLR ? 8'h00 : 8'h5A;
    after_rst_a1 = CLR ? 8'h00 : 8'h3C;
    after_rst_a0 = CLR ? 8'h00 : 8'h11;

    //          r     we    wa     din    re    ra     exp
    vecs[0]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, "reset0"};
    vecs[1]  = '{1'b0, 1'b1, 4'd0,  8'hEE, 1'b1, 4'd0,  8'h00, "reset1"};
    vecs[2]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, "reset2"};
    vecs[3]  = '{1'b1, 1'b1, 4'd0,  8'h11, 1'b0, 4'd0,  8'h00, "wr_a0"};
    vecs[4]  = '{1'b1, 1'b1, 4'd1,  8'h22, 1'b0, 4'd0,  8'h00, "wr_a1"};
    vecs[5]  = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd0,  8'h11, "rd_a0"};
    vecs[6]  = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd1,  8'h22, "rd_a1"};
    vecs[7]  = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b0, 4'd5,  8'h22, "hold0"};
    vecs[8]  = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h22, "hold1"};
    vecs[9]  = '{1'b1, 1'b1, 4'd1,  8'hA5, 1'b0, 4'd1,  8'h22, "overwrite"};
    vecs[10] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd1,  8'hA5, "rd_overwrite"};
    vecs[11] = '{1'b1, 1'b1, 4'd1,  8'h3C, 1'b1, 4'd1,  8'hA5, "collide_old"};
    vecs[12] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd1,  8'h3C, "collide_new"};
    vecs[13] = '{1'b1, 1'b1, 4'd15, 8'h77, 1'b0, 4'd0,  8'h3C, "wr_a15"};
    vecs[14] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 8'h77, "rd_a15"};
    vecs[15] = '{1'b1, 1'b1, 4'd2,  8'h5A, 1'b0, 4'd0,  8'h77, "wr_a2"};
    vecs[16] = '{1'b0, 1'b1, 4'd1,  8'hFF, 1'b1, 4'd2,  8'h00, "mid_reset"};
    vecs[17] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd2,  after_rst_a2, "rd_a2_post_rst"};
    vecs[18] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd1,  after_rst_a1, "wr_in_rst_ignored"};
    vecs[19] = '{1'b1, 1'b1, 4'd4,  8'h99, 1'b1, 4'd0,  after_rst_a0, "indep_ports"};
    vecs[20] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd4,  8'h99, "rd_a4"};

    for (int i = 0; i < 21; i++)
      cycle(vecs[i].r, vecs[i].we, vecs[i].wa, vecs[i].din,
            vecs[i].re, vecs[i].ra, vecs[i].exp, vecs[i].name);

    // Model takes over from the known output; every word gets written below.
    m_out = 8'h99;
    for (int a = 0; a < 16; a++) mcycle(1'b1, 1'b1, 4'(a), 8'(a), 1'b0, 4'd0, "fill");
    for (int a = 0; a < 16; a++) mcycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'(a), "burst_rd");
    mcycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd3, "burst_hold0");
    mcycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd7, "burst_hold1");

    for (int k = 0; k < 40; k++)
      mcycle(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), "random");

    mcycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, "final_reset");
    mcycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd9, "rd_after_final_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem1_dp_ram.md
Name: mem1_dp_ram

Overview:
- Simple dual-port synchronous RAM: one write port and one read port, both in the clk domain.
- Read data is registered, so it appears one cycle after a read request and holds between reads.
- Generic scratch/operand storage for the dotProduct datapath (vector element buffer feeding the MAC).

Parameters:
- DATA_WIDTH, 8, word width in bits.
- MEM_SIZE, 64, number of words declared in the storage array.
- ADDR_WIDTH, 4, width of write_address/read_address; effective depth DEPTH = min(MEM_SIZE, 2**ADDR_WIDTH) (16 at defaults).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- write_en  input  1  write strobe, sampled at posedge.
- write_address  input  ADDR_WIDTH  write word address.
- data_in  input  DATA_WIDTH  write data.
- read_en  input  1  read strobe, sampled at posedge.
- read_address  input  ADDR_WIDTH  read word address.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset: reset rst_n, synchronous, active-low; clock clk.
  - On a posedge with rst_n=0, data_out <= 0.
  - Writes and reads are ignored while in reset.
  - Array contents are not cleared (unknown at power-up); see the optional feature.
- Write: on a posedge with rst_n=1 and write_en=1, mem[write_address] <= data_in, provided write_address < DEPTH.
  - Out-of-range writes are dropped silently.
- Read: on a posedge with rst_n=1 and read_en=1, data_out <= mem[read_address].
  - Latency is 1 cycle: valid after the same edge that samples read_en.
  - Out-of-range reads load 0.
- Hold: with read_en=0, data_out keeps its last value indefinitely.
- Read-during-write to the same address on the same edge is read-first: data_out gets the old contents; the new data is visible from the next read.
- Write and read to different addresses on the same edge are fully independent.
- Reset asserted mid-sequence: data_out clears on that edge; stored words survive the reset.
- No handshake or back-pressure; one read and one write can be accepted every cycle.

Optional Feature:
- Macro: MEM1_RESET_CLEAR_EN.
- Defined:
  - A synchronous reset (rst_n=0 at posedge) also clears every word 0..DEPTH-1 to 0 in the same edge.
  - A read immediately after reset returns 0.
- Undefined:
  - The array is not reset (pure RAM, inferable as block/distributed RAM).
  - Reads of never-written locations return X in simulation.

Decomposition:
- Shared package mem1_pkg:
  - default constants MEM1_DATA_WIDTH=8, MEM1_MEM_SIZE=64, MEM1_ADDR_WIDTH=4;
  - helper function computing DEPTH = min(MEM_SIZE, 2**ADDR_WIDTH);
  - word typedef.
- One sub-module is natural: mem1_array, holding the storage plus the write port and the combinational read mux (in-range check).
- The top level adds the read_en-gated output register and reset.

Test Plan:
- Reset: rst_n=0 for 3 cycles -> data_out=0x00 throughout.
- Write then read:
  - Write addr0=0x11, then addr1=0x22 (one cycle each).
  - read_en, addr0 -> data_out=0x11 one edge later.
  - read_en, addr1 -> data_out=0x22.
  - After read_en drops, data_out stays 0x22.
- Overwrite: write addr1=0xA5, then read addr1 -> 0xA5.
- Read-first collision: addr1 holds 0xA5; on the same edge, write addr1=0x3C and read addr1 -> data_out=0xA5; next read of addr1 -> 0x3C.
- Boundary:
  - Write 0x77 to addr15, then read addr15 -> 0x77.
  - Fill addresses 0..15 with value=addr, then read them back-to-back (read_en held high) -> one word per cycle, 1-cycle latency.
- Reset mid-operation: write addr2=0x5A, pulse rst_n=0 for one edge -> data_out=0; then read addr2 -> 0x5A without MEM1_RESET_CLEAR_EN, 0x00 with it.
